// File: rtl/dm_responder_pkg.sv
// -----------------------------------------------------------------------------
// dm_responder_pkg
//   Shared definitions for the data-memory responder:
//     - DM_opBytes access-size codes (OP_BYTE / OP_HALF / OP_WORD)
//     - FSM state encoding (ST_IDLE / ST_WAIT / ST_RESP)
//     - dm_req_t : one latched load/store request
//     - norm_op  : maps an illegal access size onto a word access
// -----------------------------------------------------------------------------
package dm_responder_pkg;

  localparam logic [2:0] OP_BYTE = 3'd1;
  localparam logic [2:0] OP_HALF = 3'd2;
  localparam logic [2:0] OP_WORD = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [2:0]  op_bytes;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Anything other than 1 or 2 bytes is serviced as a full word.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    if (op == OP_BYTE || op == OP_HALF) begin
      return op;
    end
    return OP_WORD;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// -----------------------------------------------------------------------------
// dm_lane_unit
//   Combinational byte-lane steering for a little-endian 32-bit word array.
//   Write path: byte-enable generation and replication of right-aligned store
//   data onto every lane it could land in. Read path: extraction of the
//   addressed lanes from a stored word and sign/zero extension to 32 bits.
//
// Ports
//   i_op_bytes   : access size (1/2/4; other codes behave as 4)
//   i_addr_lo    : byte address bits [1:0]
//   i_is_signed  : 1 = sign-extend load data, 0 = zero-extend
//   i_wdata      : right-aligned store data
//   i_rword      : current contents of the addressed word
//   o_byte_en    : per-lane write enables (bit k -> bits [8k+7:8k])
//   o_wdata_rep  : store data replicated across lanes
//   o_rdata_ext  : extended load data
// -----------------------------------------------------------------------------
module dm_lane_unit
  import dm_responder_pkg::*;
(
  input  logic [2:0]  i_op_bytes,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext
);

  logic [2:0]  w_op;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_op        = norm_op(i_op_bytes);
    w_byte      = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_byte_en   = 4'b1111;
    o_wdata_rep = i_wdata;
    o_rdata_ext = i_rword;
    case (w_op)
      OP_BYTE: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{i_is_signed & w_byte[7]}}, w_byte};
      end
      OP_HALF: begin
        // Halves are placed by addr[1]; addr[0] does not move the lanes.
        o_byte_en   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{i_is_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_byte_en   = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Memory side of the MIPS datapath's DM_RE/DM_WE/DM_opBytes/DM_isSigned
//   access interface. Accepts one byte/half/word load or store per handshake,
//   waits WAIT_STATES cycles, performs the array access on the edge into the
//   response state and pulses resp_valid for one cycle with extended rdata.
//   The 2^ADDR_WIDTH x 32-bit storage array lives here and is cleared by reset.
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only in IDLE; req_valid while
//   req_ready is 0 is ignored and the requester holds its request until it
//   transfers. resp_valid is a single-cycle pulse with no back-pressure.
//
// Build option: define DM_ALIGN_CHECK_EN to add the align_err output and
//   suppress misaligned halves/words (no write, rdata = 0).
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake
//   DM_RE, DM_WE      : load / store (both = read-old-then-write, neither = no-op)
//   DM_opBytes        : 1 byte, 2 half, 4 word (others treated as word)
//   DM_isSigned       : sign-extend load data
//   addr, wdata       : byte address, right-aligned store data
//   resp_valid, rdata : completion pulse, extended load data (held)
//   o_dbg_state       : current FSM state (ST_IDLE/ST_WAIT/ST_RESP)
//   align_err         : misaligned access, coincident with resp_valid
// -----------------------------------------------------------------------------
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        DM_RE,
  input  logic        DM_WE,
  input  logic [2:0]  DM_opBytes,
  input  logic        DM_isSigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  o_dbg_state
`ifdef DM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAST_CNT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  dm_req_t     r_req;
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic [31:0] r_mem [DEPTH];

  dm_req_t                 w_in;
  dm_req_t                 w_req;
  logic                    w_fire;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_rword;
  logic [3:0]              w_byte_en;
  logic [31:0]             w_wdata_rep;
  logic [31:0]             w_rdata_ext;
  logic                    w_misaligned;
  logic                    w_do_write;
  logic [31:0]             w_load_data;
  logic                    w_unused_addr_hi;

  always_comb begin
    w_in.re        = DM_RE;
    w_in.we        = DM_WE;
    w_in.op_bytes  = DM_opBytes;
    w_in.is_signed = DM_isSigned;
    w_in.addr      = addr;
    w_in.wdata     = wdata;
  end

  // With zero wait states the access happens on the accepting edge, before
  // the request has been latched, so it is taken straight from the ports.
  assign w_req = (r_state == ST_IDLE) ? w_in : r_req;

  assign w_fire = ((r_state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                  ((r_state == ST_WAIT) && (r_cnt == LAST_CNT));

  // Upper address bits wrap onto the array.
  assign w_idx            = w_req.addr[ADDR_WIDTH+1:2];
  assign w_unused_addr_hi = &{1'b0, w_req.addr[31:ADDR_WIDTH+2]};
  assign w_rword          = r_mem[w_idx];

  dm_lane_unit u_lane (
    .i_op_bytes  (w_req.op_bytes),
    .i_addr_lo   (w_req.addr[1:0]),
    .i_is_signed (w_req.is_signed),
    .i_wdata     (w_req.wdata),
    .i_rword     (w_rword),
    .o_byte_en   (w_byte_en),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata_ext (w_rdata_ext)
  );

`ifdef DM_ALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (norm_op(w_req.op_bytes))
      OP_HALF: w_misaligned = w_req.addr[0];
      OP_WORD: w_misaligned = (w_req.addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_do_write  = w_fire && w_req.we && !w_misaligned;
  // A combined RE+WE returns the lanes as they were before this write,
  // because the array update below lands on the same edge.
  assign w_load_data = (w_req.re && !w_misaligned) ? w_rdata_ext : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_req        <= '0;
      r_rdata      <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req   <= w_in;
            r_cnt   <= 4'd0;
            r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_fire) begin
        r_rdata      <= w_load_data;
        r_misaligned <= w_misaligned;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_byte_en[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wdata_rep[8*k +: 8];
        end
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign rdata       = r_rdata;
  assign o_dbg_state = r_state;

`ifdef DM_ALIGN_CHECK_EN
  assign align_err = resp_valid && r_misaligned;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//   Two responders: index 0 with WAIT_STATES=0, index 1 with WAIT_STATES=3.
//   Expected {align_err, rdata} pairs are queued when a request is driven and
//   popped by a monitor on each resp_valid. Index 0 also carries a byte-level
//   shadow memory used for randomised traffic.
// -----------------------------------------------------------------------------
module tb_dm_responder;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        re         [2];
  logic        we         [2];
  logic [2:0]  opb        [2];
  logic        sgn        [2];
  logic [31:0] addr       [2];
  logic [31:0] wdata      [2];
  logic        resp_valid [2];
  logic [31:0] rdata      [2];
  logic [1:0]  dbg        [2];
  logic        align_err  [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [7:0]  sh [256];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  dm_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .DM_RE(re[0]), .DM_WE(we[0]), .DM_opBytes(opb[0]), .DM_isSigned(sgn[0]),
    .addr(addr[0]), .wdata(wdata[0]), .resp_valid(resp_valid[0]), .rdata(rdata[0]),
    .o_dbg_state(dbg[0])
`ifdef DM_ALIGN_CHECK_EN
    , .align_err(align_err[0])
`endif
  );

  dm_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .DM_RE(re[1]), .DM_WE(we[1]), .DM_opBytes(opb[1]), .DM_isSigned(sgn[1]),
    .addr(addr[1]), .wdata(wdata[1]), .resp_valid(resp_valid[1]), .rdata(rdata[1]),
    .o_dbg_state(dbg[1])
`ifdef DM_ALIGN_CHECK_EN
    , .align_err(align_err[1])
`endif
  );

`ifndef DM_ALIGN_CHECK_EN
  assign align_err[0] = 1'b0;
  assign align_err[1] = 1'b0;
`endif

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_valid[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        chk("unexpected_resp0", 32'd1, 32'd0);
      end else begin
        e = exp_q0.pop_front();
        chk("rdata0", rdata[0], e[31:0]);
`ifdef DM_ALIGN_CHECK_EN
        chk("align_err0", {31'h0, align_err[0]}, {31'h0, e[32]});
`endif
      end
    end
    if (resp_valid[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        chk("unexpected_resp1", 32'd1, 32'd0);
      end else begin
        e = exp_q1.pop_front();
        chk("rdata1", rdata[1], e[31:0]);
      end
    end
  end

  // ---------------- shadow model for instance 0 ----------------
  task automatic model0(input logic r, input logic w, input logic [2:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, output logic [32:0] e);
    int          n;
    logic [31:0] base;
    logic [31:0] v;
    logic [31:0] ext;
    logic        mis;
    n    = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : 4;
    base = a & ~(32'(n) - 32'd1);
    mis  = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
    mis  = (n > 1) && ((a & (32'(n) - 32'd1)) != 32'd0);
`endif
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      v[8*i +: 8] = sh[8'(base + 32'(i))];
    end
    if (n == 1)      ext = s ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
    else if (n == 2) ext = s ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
    else             ext = v;
    if (w && !mis) begin
      for (int i = 0; i < n; i++) begin
        sh[8'(base + 32'(i))] = wd[8*i +: 8];
      end
    end
    e = {mis, (r && !mis) ? ext : 32'h0};
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int d, input logic r, input logic w, input logic [2:0] op,
                       input logic s, input logic [31:0] a, input logic [31:0] wd);
    req_valid[d] = 1'b1;
    re[d]        = r;
    we[d]        = w;
    opb[d]       = op;
    sgn[d]       = s;
    addr[d]      = a;
    wdata[d]     = wd;
  endtask

  task automatic do_req(input int d, input logic r, input logic w, input logic [2:0] op,
                        input logic s, input logic [31:0] a, input logic [31:0] wd,
                        input logic [32:0] e);
    int n;
    bit seen;
    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready[d]}, 32'd1);
    drive(d, r, w, op, s, a, wd);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid[d] === 1'b1) seen = 1;
    end
    chk("latency", 32'(n), (d == 0) ? 32'd1 : 32'd4);
  endtask

  task automatic req0(input logic r, input logic w, input logic [2:0] op, input logic s,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [32:0] e;
    model0(r, w, op, s, a, wd, e);
    do_req(0, r, w, op, s, a, wd, e);
  endtask

  // Directed request on instance 0 with a fixed expected value; the shadow
  // model is still updated so later random traffic stays consistent.
  task automatic dir0(input logic r, input logic w, input logic [2:0] op, input logic s,
                      input logic [31:0] a, input logic [31:0] wd, input logic [32:0] e);
    logic [32:0] dummy;
    model0(r, w, op, s, a, wd, dummy);
    do_req(0, r, w, op, s, a, wd, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; re[d] = 1'b0; we[d] = 1'b0;
      opb[d] = 3'd4; sgn[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    for (int i = 0; i < 256; i++) sh[i] = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;

    // reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'h0, req_ready[d]}, 32'd1);
      chk("rst_resp_valid", {31'h0, resp_valid[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_state", {30'h0, dbg[d]}, 32'd0);
      chk("rst_align_err", {31'h0, align_err[d]}, 32'd0);
    end

    // word store then load
    dir0(1'b0, 1'b1, 3'd4, 1'b0, 32'h10, 32'h1234_5678, {1'b0, 32'h0});
    dir0(1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0,         {1'b0, 32'h1234_5678});

    // byte lanes
    dir0(1'b0, 1'b1, 3'd4, 1'b0, 32'h20, 32'h0,         {1'b0, 32'h0});
    dir0(1'b0, 1'b1, 3'd1, 1'b0, 32'h22, 32'h0000_00AB, {1'b0, 32'h0});
    dir0(1'b1, 1'b0, 3'd4, 1'b0, 32'h20, 32'h0,         {1'b0, 32'h00AB_0000});
    dir0(1'b1, 1'b0, 3'd1, 1'b1, 32'h22, 32'h0,         {1'b0, 32'hFFFF_FFAB});
    dir0(1'b1, 1'b0, 3'd1, 1'b0, 32'h22, 32'h0,         {1'b0, 32'h0000_00AB});

    // half lanes
    dir0(1'b0, 1'b1, 3'd2, 1'b0, 32'h1E, 32'h0000_8001, {1'b0, 32'h0});
    dir0(1'b1, 1'b0, 3'd2, 1'b1, 32'h1E, 32'h0,         {1'b0, 32'hFFFF_8001});
    dir0(1'b1, 1'b0, 3'd2, 1'b0, 32'h1E, 32'h0,         {1'b0, 32'h0000_8001});
    dir0(1'b1, 1'b0, 3'd4, 1'b0, 32'h1C, 32'h0,         {1'b0, 32'h8001_0000});

    // RE+WE returns old data, no-op returns 0, illegal size acts as word,
    // upper address bits wrap, word loads ignore isSigned
    dir0(1'b1, 1'b1, 3'd4, 1'b0, 32'h10,    32'hCAFE_F00D, {1'b0, 32'h1234_5678});
    dir0(1'b0, 1'b0, 3'd4, 1'b0, 32'h10,    32'h0,         {1'b0, 32'h0});
    dir0(1'b1, 1'b0, 3'd3, 1'b0, 32'h10,    32'h0,         {1'b0, 32'hCAFE_F00D});
    dir0(1'b1, 1'b0, 3'd4, 1'b1, 32'h4010,  32'h0,         {1'b0, 32'hCAFE_F00D});
    dir0(1'b0, 1'b1, 3'd7, 1'b0, 32'h8030,  32'h89AB_CDEF, {1'b0, 32'h0});
    dir0(1'b1, 1'b0, 3'd4, 1'b1, 32'h30,    32'h0,         {1'b0, 32'h89AB_CDEF});

`ifdef DM_ALIGN_CHECK_EN
    // misaligned word store performs no write
    dir0(1'b0, 1'b1, 3'd4, 1'b0, 32'h6, 32'hFFFF_FFFF, {1'b1, 32'h0});
    dir0(1'b1, 1'b0, 3'd4, 1'b0, 32'h4, 32'h0,         {1'b0, 32'h0});
    dir0(1'b1, 1'b1, 3'd2, 1'b1, 32'h1F, 32'h0000_1111, {1'b1, 32'h0});
    dir0(1'b1, 1'b0, 3'd4, 1'b0, 32'h1C, 32'h0,         {1'b0, 32'h8001_0000});
`endif

    // randomised aligned traffic against the shadow model
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      int          n;
      case ($urandom_range(0, 3))
        0:       op = 3'd1;
        1:       op = 3'd2;
        2:       op = 3'd4;
        default: op = 3'd3;
      endcase
      n = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : 4;
      a = 32'($urandom_range(0, 255)) & ~(32'(n) - 32'd1);
      req0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op,
           1'($urandom_range(0, 1)), a, $urandom());
    end

    // WAIT_STATES=3: ready low in cycles 1..4, resp only in cycle 4,
    // a request pulse in cycle 2 is ignored
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 32'h0);
    exp_q1.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("ws3_ready_low", {31'h0, req_ready[1]}, 32'd0);
      chk("ws3_resp_cycle", {31'h0, resp_valid[1]}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 2) begin
        drive(1, 1'b0, 1'b1, 3'd4, 1'b0, 32'h0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
      end
    end
    do_req(1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 32'h0, {1'b0, 32'h0});

    // reset while in WAIT aborts the store
    do_req(1, 1'b0, 1'b1, 3'd4, 1'b0, 32'h8, 32'h5555_AAAA, {1'b0, 32'h0});
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 3'd4, 1'b0, 32'h4, 32'h1122_3344);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", {30'h0, dbg[1]}, 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'h0, resp_valid[1]}, 32'd0);
    end
    do_req(1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h4, 32'h0, {1'b0, 32'h0});
    do_req(1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h8, 32'h0, {1'b0, 32'h0});

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
